stream_capture_fifo: RTL and testbench

- Consumer end of the registered 32-bit data path.
- Samples a `data_in` word stream every clock and optionally keeps only changed values.
- Buffers the kept words in a first-word-fall-through FIFO.
- Hands the words to a reader over a valid/ready interface, with occupancy and a sticky overflow flag for the testbench scoreboard.

---
 rtl/stream_capture_fifo_if.sv | 49 ++++
 rtl/stream_capture_fifo.sv | 115 +++++++++++
 tb/tb_stream_capture_fifo.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/stream_capture_fifo_if.sv
// stream_capture_fifo_if: capture and read-side signals of stream_capture_fifo.
//   data_in / capture_en / change_only : sampled word stream and capture controls
//   rd_valid / rd_ready / rd_data      : first-word-fall-through read handshake
//   level / overflow / clear_ovf       : occupancy, sticky drop flag and its clear
//   rd_ts                              : head timestamp (only with STREAM_CAPTURE_TIMESTAMP_EN)
// master: the producer/reader environment. slave: the FIFO.
interface stream_capture_fifo_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned TS_W   = 16
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] data_in;
  logic              capture_en;
  logic              change_only;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic [LW-1:0]     level;
  logic              overflow;
  logic              clear_ovf;

  if (TS_W == 0) begin : g_ts_w_check
    $error("stream_capture_fifo_if: TS_W must be at least 1");
  end

`ifdef STREAM_CAPTURE_TIMESTAMP_EN
  logic [TS_W-1:0]   rd_ts;

  modport master (
    output data_in, capture_en, change_only, rd_ready, clear_ovf,
    input  rd_valid, rd_data, level, overflow, rd_ts
  );
  modport slave (
    input  data_in, capture_en, change_only, rd_ready, clear_ovf,
    output rd_valid, rd_data, level, overflow, rd_ts
  );
`else
  modport master (
    output data_in, capture_en, change_only, rd_ready, clear_ovf,
    input  rd_valid, rd_data, level, overflow
  );
  modport slave (
    input  data_in, capture_en, change_only, rd_ready, clear_ovf,
    output rd_valid, rd_data, level, overflow
  );
`endif
endinterface

// File: rtl/stream_capture_fifo.sv
// stream_capture_fifo: samples a word stream, optionally keeps only changed values, and
// buffers kept words in a first-word-fall-through FIFO read over valid/ready.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : stream_capture_fifo_if.slave (capture inputs, read handshake, level, overflow)
// Optional: define STREAM_CAPTURE_TIMESTAMP_EN to store a free-running TS_W-bit cycle count
// with every accepted word and present the head's value on bus.rd_ts.
module stream_capture_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned TS_W   = 16
) (
  input logic                  clk,
  input logic                  reset,
  stream_capture_fifo_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TS_W == 0)) begin : g_param_check
    $error("stream_capture_fifo: DEPTH must be a power of two >= 2 and TS_W >= 1");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] last_q, last_d;
  logic              first_q, first_d;

  logic empty, full, push_req, pop, push, drop;

  always_comb begin
    empty    = (level_q == '0);
    full     = (level_q == FULL_LEVEL);
    push_req = bus.capture_en & (~bus.change_only | first_q | (bus.data_in != last_q));
    pop      = ~empty & bus.rd_ready;
    // A pop frees the slot the full-FIFO push writes into (wr_ptr == rd_ptr when full).
    push     = push_req & (~full | pop);
    drop     = push_req & full & ~pop;
  end

  always_comb begin
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    level_d  = level_q;
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end
    // A drop in the same cycle as clear_ovf keeps the flag set.
    ovf_d   = drop | (ovf_q & ~bus.clear_ovf);
    last_d  = bus.capture_en ? bus.data_in : last_q;
    first_d = bus.capture_en ? 1'b0 : first_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      last_q   <= '0;
      first_q  <= 1'b1;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      last_q   <= last_d;
      first_q  <= first_d;
    end
  end

  // Storage needs no reset: contents are only visible while level is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= bus.data_in;
    end
  end

  always_comb begin
    bus.rd_valid = ~empty;
    bus.rd_data  = empty ? '0 : mem[rd_ptr_q];
    bus.level    = level_q;
    bus.overflow = ovf_q;
  end

`ifdef STREAM_CAPTURE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_mem [DEPTH];
  logic [TS_W-1:0] ts_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_cnt_q <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + TS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ts_mem[wr_ptr_q] <= ts_cnt_q;
    end
  end

  always_comb begin
    bus.rd_ts = empty ? '0 : ts_mem[rd_ptr_q];
  end
`endif
endmodule

// File: tb/tb_stream_capture_fifo.sv
module tb_stream_capture_fifo;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned TS_W   = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  stream_capture_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TS_W(TS_W)) bus ();

  stream_capture_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a queue of kept words plus the capture-side history.
  logic [DATA_W-1:0] mq[$];
  int                mts[$];
  logic [DATA_W-1:0] m_last;
  logic              m_first;
  logic              m_ovf;
  int                m_ts;

  typedef struct {
    logic              rst;
    logic              cap;
    logic              chg;
    logic [DATA_W-1:0] d;
    logic              rdy;
    logic              clr;
    int                lvl;
    logic [DATA_W-1:0] head;
    logic              ovf;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mts.delete();
    m_last  = '0;
    m_first = 1'b1;
    m_ovf   = 1'b0;
    m_ts    = 0;
  endtask

  // Called #1 after an edge; next edge is then the first with ts_cnt = 0.
  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic step(input logic cap, input logic chg, input logic [DATA_W-1:0] d,
                      input logic rdy, input logic clr);
    logic mpop, mpreq;
    bus.capture_en  = cap;
    bus.change_only = chg;
    bus.data_in     = d;
    bus.rd_ready    = rdy;
    bus.clear_ovf   = clr;
    mpop  = (mq.size() != 0) && rdy;
    mpreq = cap && (!chg || m_first || (d != m_last));
    if (mpop) begin
      void'(mq.pop_front());
      void'(mts.pop_front());
    end
    if (clr) m_ovf = 1'b0;
    if (mpreq) begin
      if (mq.size() < DEPTH) begin
        mq.push_back(d);
        mts.push_back(m_ts);
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (cap) begin
      m_last  = d;
      m_first = 1'b0;
    end
    m_ts = (m_ts + 1) % (1 << TS_W);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_level"}, 64'(bus.level), 64'(mq.size()));
    check({tag, "_valid"}, 64'(bus.rd_valid), 64'(mq.size() != 0));
    check({tag, "_data"}, 64'(bus.rd_data), (mq.size() != 0) ? 64'(mq[0]) : 64'd0);
    check({tag, "_ovf"}, 64'(bus.overflow), 64'(m_ovf));
`ifdef STREAM_CAPTURE_TIMESTAMP_EN
    check({tag, "_ts"}, 64'(bus.rd_ts), (mts.size() != 0) ? 64'(mts[0]) : 64'd0);
`endif
  endtask

  task automatic check_fixed(input string tag, input int lvl, input logic [DATA_W-1:0] head,
                             input logic ovf);
    check({tag, "_level"}, 64'(bus.level), 64'(lvl));
    check({tag, "_valid"}, 64'(bus.rd_valid), 64'(lvl != 0));
    check({tag, "_data"}, 64'(bus.rd_data), 64'(head));
    check({tag, "_ovf"}, 64'(bus.overflow), 64'(ovf));
  endtask

  initial begin
    bus.data_in     = '0;
    bus.capture_en  = 1'b0;
    bus.change_only = 1'b0;
    bus.rd_ready    = 1'b0;
    bus.clear_ovf   = 1'b0;
    model_reset();

    //           rst   cap   chg   d   rdy   clr   lvl head ovf
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 5, 1'b0, 1'b0, 1, 5, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 5, 1'b0, 1'b0, 2, 5, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 7, 1'b0, 1'b0, 3, 5, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 2, 5, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1, 7, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 0, 0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1, 0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1, 0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 3, 1'b0, 1'b0, 2, 0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 3, 1'b0, 1'b0, 2, 0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 3, 1'b0, 1'b0, 2, 0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 9, 1'b0, 1'b0, 3, 0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 2, 3, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1, 9, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 0, 0, 1'b0};

    @(posedge clk);
    #1;
    do_reset();
    check_fixed("reset", 0, 0, 1'b0);

    // Directed table: basic ordering and change-only filtering.
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].rst) do_reset();
      step(vecs[i].cap, vecs[i].chg, vecs[i].d, vecs[i].rdy, vecs[i].clr);
      check_fixed($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].head, vecs[i].ovf);
    end

    // Fill, overflow, clear, and drop coincident with clear.
    do_reset();
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, DATA_W'(i), 1'b0, 1'b0);
    check_fixed("full", 8, 1, 1'b0);
    step(1'b1, 1'b0, 9, 1'b0, 1'b0);
    check_fixed("drop", 8, 1, 1'b1);
    step(1'b0, 1'b0, 0, 1'b0, 1'b1);
    check_fixed("clear", 8, 1, 1'b0);
    step(1'b1, 1'b0, 11, 1'b0, 1'b1);
    check_fixed("drop_clr", 8, 1, 1'b1);

    // Push into a full FIFO while popping, then drain across the pointer wrap.
    step(1'b1, 1'b0, 10, 1'b1, 1'b0);
    check_fixed("full_pushpop", 8, 2, 1'b1);
    for (int i = 0; i < 8; i++) begin
      logic [DATA_W-1:0] exp_head;
      exp_head = (i < 7) ? DATA_W'(i + 2) : DATA_W'(10);
      check($sformatf("drain%0d", i), 64'(bus.rd_data), 64'(exp_head));
      step(1'b0, 1'b0, 0, 1'b1, 1'b0);
    end
    check_fixed("drained", 0, 0, 1'b1);
    step(1'b0, 1'b0, 0, 1'b1, 1'b1);

    // Asynchronous reset mid-stream, then first_flag re-arms change-only capture.
    do_reset();
    for (int i = 4; i <= 7; i++) step(1'b1, 1'b1, DATA_W'(i), 1'b0, 1'b0);
    check_fixed("pre_rst", 4, 4, 1'b0);
    bus.capture_en = 1'b0;
    reset = 1'b1;
    #1;
    check("async_rst_level", 64'(bus.level), 64'd0);
    check("async_rst_valid", 64'(bus.rd_valid), 64'd0);
    #1;
    reset = 1'b0;
    model_reset();
    step(1'b1, 1'b1, 7, 1'b0, 1'b0);
    check_fixed("post_rst", 1, 7, 1'b0);

    // Empty FIFO: push and pop together keeps the push.
    do_reset();
    step(1'b1, 1'b0, 32'hABCD, 1'b1, 1'b0);
    check_fixed("empty_pushpop", 1, 32'hABCD, 1'b0);

`ifdef STREAM_CAPTURE_TIMESTAMP_EN
    do_reset();
    step(1'b0, 1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'hA, 1'b0, 1'b0);
    check("ts_first", 64'(bus.rd_ts), 64'd2);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'hB, 1'b0, 1'b0);
    check("ts_head", 64'(bus.rd_ts), 64'd2);
    step(1'b0, 1'b0, 0, 1'b1, 1'b0);
    check("ts_wrapped", 64'(bus.rd_ts), 64'd2);
    check("ts_wrapped_data", 64'(bus.rd_data), 64'hB);
`endif

    // Randomized traffic against the queue model, with varying reader pressure.
    do_reset();
    check_model("rnd_reset");
    for (int phase = 0; phase < 4; phase++) begin
      int rdy_pct;
      rdy_pct = (phase == 0) ? 20 : (phase == 1) ? 50 : (phase == 2) ? 85 : 35;
      for (int i = 0; i < 500; i++) begin
        step($urandom_range(0, 99) < 75, 1'($urandom_range(0, 1)),
             DATA_W'($urandom_range(0, 3)), $urandom_range(0, 99) < rdy_pct,
             $urandom_range(0, 99) < 8);
        check_model("rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
